// File: rtl/ime_pkg.sv
// Shared types and default constants for the integer motion-estimation search path.
package ime_pkg;

   localparam int SRCH_RANGE_DEF = 8;
   localparam int SAD_W_DEF      = 12;
   localparam int SAD_LAT_DEF    = 2;
   localparam int MV_W_DEF       = $clog2(SRCH_RANGE_DEF) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic signed [MV_W_DEF-1:0] mv_t;
   typedef logic [SAD_W_DEF-1:0]       sad_t;

   // Offset width able to hold -R..R-1 in two's complement.
   function automatic int mv_width(input int range);
      return $clog2(range) + 1;
   endfunction

endpackage

// File: rtl/ime_search_ctrl_if.sv
// Handshake bundle between the IME top-level control, the search sequencer and the PE array.
interface ime_search_ctrl_if
   import ime_pkg::*;
#(
   parameter int SAD_W = SAD_W_DEF,
   parameter int MV_W  = MV_W_DEF
);

   logic                    start;
   logic                    abort;
   logic                    ref_ready;
   logic [SAD_W-1:0]        sad_in;
   logic                    busy;
   logic                    pe_roll;
   logic signed [MV_W-1:0]  cand_dx;
   logic signed [MV_W-1:0]  cand_dy;
   logic                    done;
   logic [SAD_W-1:0]        best_sad;
   logic signed [MV_W-1:0]  best_dx;
   logic signed [MV_W-1:0]  best_dy;

   modport master (
      output start, abort, ref_ready, sad_in,
      input  busy, pe_roll, cand_dx, cand_dy, done, best_sad, best_dx, best_dy
   );

   modport slave (
      input  start, abort, ref_ready, sad_in,
      output busy, pe_roll, cand_dx, cand_dy, done, best_sad, best_dx, best_dy
   );

endinterface

// File: rtl/ime_tag_pipe.sv
// Fixed-latency valid+offset shift register that tags each returning SAD with its candidate.
module ime_tag_pipe
   import ime_pkg::*;
#(
   parameter int LAT  = SAD_LAT_DEF,
   parameter int MV_W = MV_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic signed [MV_W-1:0] in_dx,
   input  logic signed [MV_W-1:0] in_dy,
   output logic                   out_valid,
   output logic signed [MV_W-1:0] out_dx,
   output logic signed [MV_W-1:0] out_dy
);

   logic [LAT-1:0]            valid_reg;
   logic [LAT-1:0][MV_W-1:0]  dx_reg;
   logic [LAT-1:0][MV_W-1:0]  dy_reg;

   // Flush only kills the valid bits; stale offsets are harmless once invalid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg <= '0;
         dx_reg    <= '0;
         dy_reg    <= '0;
      end else begin
         valid_reg[0] <= in_valid & ~flush;
         dx_reg[0]    <= in_dx;
         dy_reg[0]    <= in_dy;
         for (int i = 1; i < LAT; i++) begin
            valid_reg[i] <= valid_reg[i-1] & ~flush;
            dx_reg[i]    <= dx_reg[i-1];
            dy_reg[i]    <= dy_reg[i-1];
         end
      end
   end

   assign out_valid = valid_reg[LAT-1];
   assign out_dx    = dx_reg[LAT-1];
   assign out_dy    = dy_reg[LAT-1];

endmodule

// File: rtl/ime_search_ctrl.sv
// Raster-order integer ME search sequencer: issues every offset of the search window
// to the PE array, tracks the minimum SAD and reports the best motion vector.
module ime_search_ctrl
   import ime_pkg::*;
#(
   parameter int SRCH_RANGE = SRCH_RANGE_DEF,
   parameter int SAD_W      = SAD_W_DEF,
   parameter int SAD_LAT    = SAD_LAT_DEF
) (
   input logic              clk,
   input logic              rst,
   ime_search_ctrl_if.slave bus
);

   localparam int MV_W = mv_width(SRCH_RANGE);
   localparam logic [MV_W-1:0]        R_OFF    = MV_W'(SRCH_RANGE);
   localparam logic [MV_W-1:0]        IDX_LAST = MV_W'(2 * SRCH_RANGE - 1);
   localparam logic signed [MV_W-1:0] MV_LAST  = MV_W'(SRCH_RANGE - 1);

   state_t                  state_reg, state_next;
   logic [MV_W-1:0]         idx_x_reg, idx_y_reg;
   logic signed [MV_W-1:0]  cand_dx_reg, cand_dy_reg;
   logic [SAD_W-1:0]        work_sad_reg, work_sad_next;
   logic signed [MV_W-1:0]  work_dx_reg, work_dx_next;
   logic signed [MV_W-1:0]  work_dy_reg, work_dy_next;
   logic                    work_have_reg, work_have_next;
   logic [SAD_W-1:0]        best_sad_reg;
   logic signed [MV_W-1:0]  best_dx_reg, best_dy_reg;

   logic                    active, accept, issue, last_issue, flush;
   logic                    take, last_sample;
   logic signed [MV_W-1:0]  cur_dx, cur_dy;
   logic                    tag_valid;
   logic signed [MV_W-1:0]  tag_dx, tag_dy;

   assign active     = (state_reg == ISSUE) || (state_reg == DRAIN);
   assign accept     = (state_reg == IDLE) && bus.start && !bus.abort;
   assign issue      = (state_reg == ISSUE) && bus.ref_ready && !bus.abort;
   assign last_issue = issue && (idx_x_reg == IDX_LAST) && (idx_y_reg == IDX_LAST);
   assign flush      = active && bus.abort;

   // Indices run 0..2R-1; subtracting R gives the signed offset directly.
   assign cur_dx = $signed(idx_x_reg - R_OFF);
   assign cur_dy = $signed(idx_y_reg - R_OFF);

   ime_tag_pipe #(
      .LAT  (SAD_LAT),
      .MV_W (MV_W)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (issue),
      .in_dx     (cur_dx),
      .in_dy     (cur_dy),
      .out_valid (tag_valid),
      .out_dx    (tag_dx),
      .out_dy    (tag_dy)
   );

   assign take        = tag_valid && (!work_have_reg || (bus.sad_in < work_sad_reg));
   assign last_sample = tag_valid && (tag_dx == MV_LAST) && (tag_dy == MV_LAST);

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept) state_next = ISSUE;
         ISSUE: begin
            if (bus.abort)       state_next = IDLE;
            else if (last_issue) state_next = DRAIN;
         end
         DRAIN: begin
            if (bus.abort)        state_next = IDLE;
            else if (last_sample) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strict less-than keeps the earliest raster candidate on ties.
   always_comb begin
      work_sad_next  = work_sad_reg;
      work_dx_next   = work_dx_reg;
      work_dy_next   = work_dy_reg;
      work_have_next = work_have_reg;
      if (accept) begin
         work_have_next = 1'b0;
      end else if (take) begin
         work_sad_next  = bus.sad_in;
         work_dx_next   = tag_dx;
         work_dy_next   = tag_dy;
         work_have_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_x_reg   <= '0;
         idx_y_reg   <= '0;
         cand_dx_reg <= '0;
         cand_dy_reg <= '0;
      end else if (accept) begin
         idx_x_reg <= '0;
         idx_y_reg <= '0;
      end else if (issue) begin
         cand_dx_reg <= cur_dx;
         cand_dy_reg <= cur_dy;
         if (idx_x_reg == IDX_LAST) begin
            idx_x_reg <= '0;
            idx_y_reg <= idx_y_reg + MV_W'(1);
         end else begin
            idx_x_reg <= idx_x_reg + MV_W'(1);
         end
      end
   end

   // Results are published on the edge entering DONE so they coincide with the done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         work_sad_reg  <= '0;
         work_dx_reg   <= '0;
         work_dy_reg   <= '0;
         work_have_reg <= 1'b0;
         best_sad_reg  <= '0;
         best_dx_reg   <= '0;
         best_dy_reg   <= '0;
      end else begin
         work_sad_reg  <= work_sad_next;
         work_dx_reg   <= work_dx_next;
         work_dy_reg   <= work_dy_next;
         work_have_reg <= work_have_next;
         if (state_next == DONE) begin
            best_sad_reg <= work_sad_next;
            best_dx_reg  <= work_dx_next;
            best_dy_reg  <= work_dy_next;
         end
      end
   end

   assign bus.busy     = active;
   assign bus.pe_roll  = issue;
   assign bus.cand_dx  = issue ? cur_dx : cand_dx_reg;
   assign bus.cand_dy  = issue ? cur_dy : cand_dy_reg;
   assign bus.done     = (state_reg == DONE);
   assign bus.best_sad = best_sad_reg;
   assign bus.best_dx  = best_dx_reg;
   assign bus.best_dy  = best_dy_reg;

endmodule

// File: tb/tb_ime_search_ctrl.sv
// Bench for ime_search_ctrl: a small R=2 instance against a behavioural search model
// under directed and random stimulus, plus an R=8 instance for the boundary case.
module tb_ime_search_ctrl;
   import ime_pkg::*;

   localparam int RA  = 2;
   localparam int LAT = 2;
   localparam int SW  = 12;
   localparam int MVA = $clog2(RA) + 1;
   localparam int NA  = 4 * RA * RA;
   localparam int RB  = 8;
   localparam int MVB = $clog2(RB) + 1;
   localparam int NB  = 4 * RB * RB;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ime_search_ctrl_if #(.SAD_W(SW), .MV_W(MVA)) a_if ();
   ime_search_ctrl_if #(.SAD_W(SW), .MV_W(MVB)) b_if ();

   ime_search_ctrl #(.SRCH_RANGE(RA), .SAD_W(SW), .SAD_LAT(LAT)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   ime_search_ctrl #(.SRCH_RANGE(RB), .SAD_W(SW), .SAD_LAT(LAT)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   int stall_mode = 0;
   int tab_a [NA];
   int tab_b [NB];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // PE array stand-in: SAD for a candidate appears LAT cycles after its pe_roll; junk otherwise.
   logic [SW-1:0] pa0, pa1, pb0, pb1;
   always @(posedge clk) begin
      pa0 <= a_if.pe_roll ? SW'(tab_a[(int'(a_if.cand_dy) + RA) * 2 * RA + int'(a_if.cand_dx) + RA])
                          : SW'($urandom);
      pa1 <= pa0;
      pb0 <= b_if.pe_roll ? SW'(tab_b[(int'(b_if.cand_dy) + RB) * 2 * RB + int'(b_if.cand_dx) + RB])
                          : SW'($urandom);
      pb1 <= pb0;
   end
   assign a_if.sad_in = pa1;
   assign b_if.sad_in = pb1;

   // Behavioural model of the R=2 instance.
   bit m_busy = 1'b0;
   int m_issued = 0;
   int m_done_cyc = -1;
   int m_esad = 0, m_edx = 0, m_edy = 0;
   int m_bsad = 0, m_bdx = 0, m_bdy = 0;
   int m_cdx = 0, m_cdy = 0;

   int obs_done_n = 0, obs_done_cyc = -1, obs_rolls = 0, obs_bf = -1, obs_bl = -1;
   int ob_done_n = 0, ob_done_cyc = -1, ob_rolls = 0;

   task automatic model_accept();
      int bk;
      bk = 0;
      for (int k = 1; k < NA; k++)
         if (tab_a[k] < tab_a[bk]) bk = k;
      m_esad = tab_a[bk];
      m_edx  = bk % (2 * RA) - RA;
      m_edy  = bk / (2 * RA) - RA;
   endtask

   task automatic check_a();
      int  c;
      bit  roll_e;
      c = cyc;
      if (!rst) begin
         m_busy = 1'b0; m_done_cyc = -1;
         m_bsad = 0; m_bdx = 0; m_bdy = 0; m_cdx = 0; m_cdy = 0;
      end else if (c == m_done_cyc) begin
         m_bsad = m_esad; m_bdx = m_edx; m_bdy = m_edy;
      end
      roll_e = rst && m_busy && (m_issued < NA) && a_if.ref_ready && !a_if.abort;
      if (roll_e) begin
         m_cdx = m_issued % (2 * RA) - RA;
         m_cdy = m_issued / (2 * RA) - RA;
      end
      chk("a_busy", int'(a_if.busy), int'(m_busy));
      chk("a_pe_roll", int'(a_if.pe_roll), int'(roll_e));
      chk("a_done", int'(a_if.done), int'(rst && (c == m_done_cyc)));
      chk("a_cand_dx", int'(a_if.cand_dx), m_cdx);
      chk("a_cand_dy", int'(a_if.cand_dy), m_cdy);
      chk("a_best_sad", int'(a_if.best_sad), m_bsad);
      chk("a_best_dx", int'(a_if.best_dx), m_bdx);
      chk("a_best_dy", int'(a_if.best_dy), m_bdy);
      if (a_if.done) begin obs_done_n++; obs_done_cyc = c; end
      if (a_if.pe_roll) obs_rolls++;
      if (a_if.busy) begin
         if (obs_bf < 0) obs_bf = c;
         obs_bl = c;
      end
      if (rst) begin
         if (m_busy) begin
            if (a_if.abort) begin
               m_busy = 1'b0; m_done_cyc = -1;
            end else begin
               if (roll_e) begin
                  m_issued++;
                  if (m_issued == NA) m_done_cyc = c + LAT + 1;
               end
               if (c + 1 == m_done_cyc) m_busy = 1'b0;
            end
         end else if (c != m_done_cyc && a_if.start && !a_if.abort) begin
            m_busy = 1'b1; m_issued = 0;
            model_accept();
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         check_a();
         if (b_if.done) begin ob_done_n++; ob_done_cyc = cyc; end
         if (b_if.pe_roll) ob_rolls++;
      end
   end

   task automatic step();
      @(negedge clk);
      case (stall_mode)
         1:       a_if.ref_ready = (cyc % 3) != 0;
         2:       a_if.ref_ready = ($urandom % 4) != 0;
         default: a_if.ref_ready = 1'b1;
      endcase
   endtask

   task automatic fill_a(input int kind);
      for (int k = 0; k < NA; k++) begin
         case (kind)
            0:       tab_a[k] = iabs(k % (2 * RA) - RA - 1) + iabs(k / (2 * RA) - RA + 1) + 5;
            1:       tab_a[k] = 7;
            2:       tab_a[k] = $urandom_range(0, 7);
            default: tab_a[k] = $urandom_range(0, 4095);
         endcase
      end
   endtask

   task automatic run_a(input int kind, output int st);
      fill_a(kind);
      obs_done_n = 0; obs_done_cyc = -1; obs_rolls = 0; obs_bf = -1; obs_bl = -1;
      a_if.start = 1'b1;
      st = cyc;
      step();
      a_if.start = 1'b0;
      for (int i = 0; i < 300 && obs_done_n == 0; i++) step();
      if (obs_done_n == 0) chk("a_done_timeout", 0, 1);
      step();
   endtask

   task automatic pin_a(input string nm, input int dx, input int dy, input int sad);
      chk({nm, "_best_dx"}, int'(a_if.best_dx), dx);
      chk({nm, "_best_dy"}, int'(a_if.best_dy), dy);
      chk({nm, "_best_sad"}, int'(a_if.best_sad), sad);
      chk({nm, "_rolls"}, obs_rolls, NA);
   endtask

   initial begin
      int st;
      a_if.start = 1'b0; a_if.abort = 1'b0; a_if.ref_ready = 1'b1;
      b_if.start = 1'b0; b_if.abort = 1'b0; b_if.ref_ready = 1'b1;
      for (int k = 0; k < NB; k++) tab_b[k] = 4095;
      tab_b[NB - 1] = 0;
      repeat (3) step();
      chk("b_reset_busy", int'(b_if.busy), 0);
      chk("b_reset_best_sad", int'(b_if.best_sad), 0);
      chk("b_reset_cand_dx", int'(b_if.cand_dx), 0);
      rst = 1'b1;
      step();

      // Basic search.
      run_a(0, st);
      pin_a("basic", 1, -1, 5);
      chk("basic_latency", obs_done_cyc - st, 19);
      chk("basic_busy_first", obs_bf - st, 1);
      chk("basic_busy_last", obs_bl - st, 18);

      // Tie rule.
      run_a(1, st);
      pin_a("tie", -2, -2, 7);
      chk("tie_latency", obs_done_cyc - st, 19);

      // Stalls on every third cycle.
      stall_mode = 1;
      run_a(0, st);
      stall_mode = 0;
      pin_a("stall", 1, -1, 5);
      chk("stall_delayed", int'(obs_done_cyc - st > 19), 1);

      // Abort at cycle 8 of a search that would otherwise change the result.
      fill_a(1);
      obs_done_n = 0; obs_rolls = 0;
      a_if.start = 1'b1;
      st = cyc;
      step();
      a_if.start = 1'b0;
      while (cyc < st + 8) step();
      a_if.abort = 1'b1;
      step();
      a_if.abort = 1'b0;
      chk("abort_idle", int'(a_if.busy), 0);
      repeat (25) step();
      chk("abort_no_done", obs_done_n, 0);
      chk("abort_best_dx", int'(a_if.best_dx), 1);
      chk("abort_best_sad", int'(a_if.best_sad), 5);
      run_a(1, st);
      pin_a("post_abort", -2, -2, 7);

      // Reset in the middle of DRAIN.
      fill_a(0);
      a_if.start = 1'b1;
      st = cyc;
      step();
      a_if.start = 1'b0;
      while (cyc < st + 17) step();
      rst = 1'b0;
      #2;
      chk("rst_busy", int'(a_if.busy), 0);
      chk("rst_best_sad", int'(a_if.best_sad), 0);
      chk("rst_best_dx", int'(a_if.best_dx), 0);
      chk("rst_best_dy", int'(a_if.best_dy), 0);
      step();
      rst = 1'b1;
      step();
      run_a(0, st);
      pin_a("post_rst", 1, -1, 5);
      chk("post_rst_latency", obs_done_cyc - st, 19);

      // Random tables, ready gaps, starts while busy and stray aborts.
      stall_mode = 2;
      for (int i = 0; i < 1200; i++) begin
         step();
         if (!m_busy) fill_a(2 + int'($urandom % 2));
         a_if.start = ($urandom % 5) == 0;
         a_if.abort = ($urandom % 60) == 0;
      end
      a_if.start = 1'b0;
      a_if.abort = 1'b0;
      stall_mode = 0;
      repeat (30) step();

      // Boundary: R=8, single zero SAD at the last candidate, start pulsed while busy.
      ob_done_n = 0; ob_rolls = 0; ob_done_cyc = -1;
      b_if.start = 1'b1;
      st = cyc;
      step();
      b_if.start = 1'b0;
      while (cyc < st + 50) step();
      b_if.start = 1'b1;
      step();
      b_if.start = 1'b0;
      chk("b_busy_hold", int'(b_if.busy), 1);
      for (int i = 0; i < 400 && ob_done_n == 0; i++) step();
      step();
      chk("b_done_count", ob_done_n, 1);
      chk("b_latency", ob_done_cyc - st, NB + LAT + 1);
      chk("b_rolls", ob_rolls, NB);
      chk("b_best_dx", int'(b_if.best_dx), 7);
      chk("b_best_dy", int'(b_if.best_dy), 7);
      chk("b_best_sad", int'(b_if.best_sad), 0);
      repeat (5) step();
      chk("b_no_restart", ob_rolls, NB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ime_search_ctrl.md
Name: ime_search_ctrl

Overview:
Sequencer for the integer-motion-estimation 4x4 SAD processing-element array. On `start` it walks every integer offset of a square search window in raster order. For each offset it issues one candidate, with a `pe_roll` pulse and the offset, to the reference fetch and the PE array. It collects the SAD returned a fixed latency later and keeps a running minimum. It reports the best motion vector and its SAD with a one-cycle `done` pulse. It sits between the IME top-level control and the PE array / reference-window buffer.

Parameters:
- SRCH_RANGE, 8, half-width R of the search window; offsets run -R..R-1 in both axes; must be a power of two, at least 2.
- SAD_W, 12, width of the SAD returned by the PE array; compared as unsigned.
- SAD_LAT, 2, cycles from a candidate issue (`pe_roll` high) to its SAD being valid on `sad_in`; at least 1.
- MV_W, $clog2(SRCH_RANGE)+1, derived two's-complement offset width (4 for R=8).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a search; sampled only in IDLE.
- abort  in  1  cancels an active search.
- ref_ready  in  1  reference window can accept a new offset this cycle.
- sad_in  in  SAD_W  SAD from the PE array.
- busy  out  1  high from the cycle after `start` is accepted until `done` or abort.
- pe_roll  out  1  one-cycle candidate issue strobe to the PE array.
- cand_dx  out  MV_W  signed x offset of the issued candidate.
- cand_dy  out  MV_W  signed y offset of the issued candidate.
- done  out  1  one-cycle pulse when results are final.
- best_sad  out  SAD_W  minimum SAD of the last completed search.
- best_dx  out  MV_W  x offset of that minimum.
- best_dy  out  MV_W  y offset of that minimum.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output 0; candidate counters and the tag pipeline cleared.
- States:
  - IDLE -> ISSUE on start=1.
  - ISSUE -> DRAIN once the last candidate has been issued.
  - DRAIN -> DONE when the last SAD has been sampled.
  - DONE -> IDLE unconditionally.
- Candidate ordering:
  - N=(2R)^2 candidates.
  - dy is the outer loop and dx the inner loop, each counting -R up to R-1.
  - The first candidate is (-R,-R); the last is (R-1,R-1).
- Issue:
  - In ISSUE with ref_ready=1, `pe_roll`=1 and `cand_dx`/`cand_dy` carry the current offset; the counter advances.
  - With ref_ready=0, `pe_roll`=0, the offset is held and no candidate is issued (a stall).
  - `cand_dx`/`cand_dy` hold their last value when `pe_roll`=0.
- Tag pipeline:
  - An SAD_LAT-deep shift register carries a valid bit plus (dx,dy) alongside each issue.
  - At its output, `sad_in` is sampled for that tag.
  - Stalls insert bubbles (valid=0); `sad_in` is ignored on bubble cycles.
- Minimum tracking:
  - The first valid SAD of a search loads unconditionally.
  - Later SADs replace the stored value only on strict sad_in < stored.
  - Ties keep the earlier candidate in raster order.
  - Working registers are separate from the `best_*` outputs.
- Completion:
  - In the DONE cycle, `done`=1 and `best_*` update from the working registers.
  - `best_*` then hold until the next completed search.
  - With no stalls, start-to-done is N+SAD_LAT+1 cycles, where start is sampled high at cycle 0.
- `busy` is high in ISSUE and DRAIN, and low in IDLE and DONE.
- `start` while busy: ignored.
- `start` in the DONE cycle: ignored; it must be re-asserted in IDLE.
- Abort:
  - abort=1 in ISSUE/DRAIN returns to IDLE the next cycle.
  - In-flight tags are flushed; no `done` is produced; `best_*` keep their previous values.
  - abort in IDLE/DONE has no effect.
  - abort together with start in IDLE: abort wins; the search does not start.
- Reset mid-search: immediate return to IDLE; all outputs 0.
- The SAD comparison is unsigned over the full SAD_W bits; there is no saturation.

Decomposition:
- Package `ime_pkg`:
  - state enum (IDLE, ISSUE, DRAIN, DONE).
  - `mv_t`, a signed MV_W offset type.
  - `sad_t`, the SAD_W type.
  - default SRCH_RANGE / SAD_LAT constants.
- Sub-module `ime_tag_pipe`: the SAD_LAT-deep valid+mv shift register with flush input. It is reused by later fractional-ME stages.
- The FSM, raster counters and min tracker stay in `ime_search_ctrl`.

Test Plan:
- Basic search (R=2, LAT=2, ref_ready=1, model SAD=|dx-1|+|dy+1|+5): `done` at cycle 19; best=(1,-1); best_sad=5; exactly 16 `pe_roll` pulses; `busy` spans cycles 1-18.
- Tie rule (constant SAD=7 for every candidate): best=(-2,-2), best_sad=7.
- Stalls (ref_ready low on every third cycle, same SAD model as the basic search): result identical to the basic search; offsets are never skipped or duplicated; `done` is delayed by the stall count.
- Abort (abort at cycle 8 of a search): IDLE at cycle 9, no `done`, `best_*` unchanged from the prior search. A new start then gives a correct result.
- Reset mid-DRAIN (rst low for 1 cycle): all outputs 0 asynchronously. A following start runs a full 16-candidate search.
- Boundary (R=8, SAD_W=12, SAD=4095 everywhere except 0 at (7,7)): best=(7,7), best_sad=0; start while busy is ignored.
